nios_system_switch_ctrl: RTL and testbench

Avalon-MM slave controller for the board slide switches. It synchronises and debounces a WIDTH-bit raw switch bus and exposes the debounced value, the raw synchronised value and a per-bit edge-capture register. It raises a maskable level interrupt toward the Nios II processor. It replaces a plain input PIO on the same slave slot; readdata keeps the same 1-cycle registered read latency.

---
 rtl/nios_system_switch_ctrl.sv | 145 ++++++++++++++
 tb/tb_nios_system_switch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_switch_ctrl.sv
// Avalon-MM slide-switch controller: 2-flop sync, per-bit tick-sampled debounce, edge capture, level irq.
// Define SWITCH_CTRL_IRQ_EN to implement IRQMASK and drive irq; otherwise irq is tied low.
module nios_system_switch_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IW = 5;

    typedef enum logic {IDLE, PEND} db_state_t;

    logic [WIDTH-1:0] sync1, raw;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] edge_cap, cap_d, edge_evt, wr_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [PW-1:0]    presc;
    logic [IW-1:0]    init_cnt;
    logic             tick, armed, wr_en;
    logic [31:0]      rd_d;
    db_state_t        st_q  [WIDTH];
    db_state_t        st_d  [WIDTH];
    logic [3:0]       cnt_q [WIDTH];
    logic [3:0]       cnt_d [WIDTH];
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign tick         = (presc == PW'(TICK_DIV - 1));
    assign armed        = (init_cnt == IW'(STABLE_TICKS + 1));
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            raw      <= '0;
            presc    <= '0;
            init_cnt <= '0;
        end else begin
            sync1 <= in_port;
            raw   <= sync1;
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && !armed)
                init_cnt <= init_cnt + 1'b1;
        end
    end

    // One debounce FSM per bit; cnt holds the number of consecutive mismatching ticks seen so far.
    always_comb begin
        logic [3:0] nxt;
        data_d   = data_q;
        edge_evt = '0;
        nxt      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (raw[i] == data_q[i]) begin
                    st_d[i]  = IDLE;
                    cnt_d[i] = '0;
                end else begin
                    nxt = (st_q[i] == PEND) ? cnt_q[i] + 4'd1 : 4'd1;
                    if (nxt == 4'(STABLE_TICKS)) begin
                        data_d[i]   = ~data_q[i];
                        edge_evt[i] = 1'b1;
                        st_d[i]     = IDLE;
                        cnt_d[i]    = '0;
                    end else begin
                        st_d[i]  = PEND;
                        cnt_d[i] = nxt;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A same-cycle edge event overrides the write-1-to-clear.
    assign wr_clr = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    assign cap_d  = (edge_cap & ~wr_clr) | (armed ? edge_evt : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            edge_cap <= '0;
        else
            edge_cap <= cap_d;
    end

`ifdef SWITCH_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && address == 2'd1)
                irq_mask <= writedata[WIDTH-1:0];
            irq <= |(edge_cap & irq_mask);
        end
    end
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_d = '0;
        case (address)
            2'd0: rd_d[WIDTH-1:0] = data_q;
            2'd1: rd_d[WIDTH-1:0] = irq_mask;
            2'd2: rd_d[WIDTH-1:0] = edge_cap;
            2'd3: rd_d[WIDTH-1:0] = raw;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_d;
    end
endmodule

// File: tb/tb_nios_system_switch_ctrl.sv
// Self-checking bench for nios_system_switch_ctrl: register table, directed debounce sequences,
// and randomized traffic checked every cycle against a tick/streak reference model.
module tb_nios_system_switch_ctrl;
    localparam int W  = 8;
    localparam int TD = 4;
    localparam int ST = 3;
`ifdef SWITCH_CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [1:0]    address    = '0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = '0;
    logic [W-1:0]  in_port    = '0;
    logic [31:0]   readdata;
    logic          irq;

    nios_system_switch_ctrl #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: switch level is accepted after ST consecutive mismatching sample ticks.
    logic [W-1:0] m_s1, m_s2, m_data, m_mask, m_ecap;
    logic [31:0]  m_rd;
    logic         m_irq;
    int           m_cyc, m_ticks;
    int           m_streak [W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_data = '0; m_mask = '0; m_ecap = '0;
        m_rd = '0; m_irq = 1'b0; m_cyc = 0; m_ticks = 0;
        for (int b = 0; b < W; b++) m_streak[b] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] raw, nd, ne, nm;
        logic [31:0]  rd;
        bit           tk;
        raw = m_s2;
        tk  = (m_cyc % TD) == TD - 1;
        case (address)
            2'd0:    rd = 32'(m_data);
            2'd1:    rd = 32'(m_mask);
            2'd2:    rd = 32'(m_ecap);
            default: rd = 32'(raw);
        endcase
        nd = m_data; ne = m_ecap; nm = m_mask;
        if (chipselect && !write_n) begin
            if (address == 2'd1 && IRQ_EN) nm = writedata[W-1:0];
            if (address == 2'd2) ne = ne & ~writedata[W-1:0];
        end
        if (tk) begin
            for (int b = 0; b < W; b++) begin
                if (raw[b] != m_data[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == ST) begin
                        nd[b] = ~nd[b];
                        m_streak[b] = 0;
                        if (m_ticks >= ST + 1) ne[b] = 1'b1;
                    end
                end else begin
                    m_streak[b] = 0;
                end
            end
            m_ticks++;
        end
        m_irq  = IRQ_EN && |(m_ecap & m_mask);
        m_rd   = rd;
        m_cyc++;
        m_s2   = m_s1;
        m_s1   = in_port;
        m_data = nd;
        m_ecap = ne;
        m_mask = nm;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check("model_readdata", readdata, m_rd);
        check("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input logic [1:0] a);
        chipselect = 1'b0; write_n = 1'b1; address = a; writedata = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    endtask

    typedef struct {
        logic        cs;
        logic        we;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mv;
        int          lat, guard;
        bit          seen, stuck;

        mv = IRQ_EN ? 32'h5A : 32'h0;
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 1'b0, 2'd3, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 1'b1, 2'd1, 32'hFFFFFF5A, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 2'd1, 32'h0,        mv};
        tbl[6]  = '{1'b1, 1'b1, 2'd0, 32'hFF,       32'h0};
        tbl[7]  = '{1'b1, 1'b1, 2'd3, 32'hFF,       32'h0};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h0};
        tbl[9]  = '{1'b1, 1'b1, 2'd2, 32'hFF,       32'h0};
        tbl[10] = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 1'b1, 2'd1, 32'h0,        mv};
        tbl[12] = '{1'b0, 1'b0, 2'd1, 32'h0,        mv};
        tbl[13] = '{1'b1, 1'b1, 2'd1, 32'h0,        mv};
        tbl[14] = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h0};

        m_reset();
        idle(0);
        repeat (3) step();
        reset_n = 1'b1;

        // Reset values and register map
        for (int i = 0; i < 15; i++) begin
            chipselect = tbl[i].cs; write_n = ~tbl[i].we; address = tbl[i].a; writedata = tbl[i].d;
            step();
            check($sformatf("tbl[%0d]_readdata", i), readdata, tbl[i].exp_rd);
            check($sformatf("tbl[%0d]_irq", i), 32'(irq), 32'h0);
        end
        idle(0);
        repeat (12) step();

        // Clean change 0x00 -> 0x05
        in_port = 8'h05; address = 2'd3;
        step(); step();
        check("raw_before_sync", readdata, 32'h0);
        step();
        check("raw_after_sync", readdata, 32'h5);
        address = 2'd0; lat = -1;
        for (int n = 4; n <= 30 && lat < 0; n++) begin
            step();
            if (readdata == 32'h5) lat = n - 1;
        end
        check("clean_latency_in_11_14", 32'(lat >= 11 && lat <= 14), 32'h1);
        address = 2'd2; step();
        check("clean_edgecap", readdata, 32'h5);

        // Bounce rejection on bit0
        in_port = '0; idle(0);
        repeat (25) step();
        wr(2, 32'hFF); step(); idle(0);
        stuck = 1'b0;
        in_port = 8'h01; repeat (5) begin step(); stuck |= readdata[0]; end
        in_port = 8'h00; repeat (5) begin step(); stuck |= readdata[0]; end
        in_port = 8'h01;
        repeat (10) begin step(); stuck |= readdata[0]; end
        check("bounce_no_toggle", 32'(stuck), 32'h0);
        lat = -1;
        for (int n = 11; n <= 30 && lat < 0; n++) begin
            step();
            if (readdata[0]) lat = n - 1;
        end
        check("bounce_latency_in_11_14", 32'(lat >= 11 && lat <= 14), 32'h1);

        // Interrupt and W1C
        wr(1, 32'h1); step(); idle(2);
        wr(2, 32'hFF); step(); idle(2);
        in_port = in_port ^ 8'h03;
        repeat (20) step();
        check("irq_set", 32'(irq), 32'(IRQ_EN));
        check("edgecap_two_bits", readdata, 32'h3);
        wr(2, 32'h1); step();
        check("irq_hold_on_w1c_edge", 32'(irq), 32'(IRQ_EN));
        idle(2); step();
        check("irq_after_w1c", 32'(irq), 32'h0);
        check("edgecap_after_w1c", readdata, 32'h2);

        // Set/clear collision on bit2: W1C held every cycle while bit2 debounces
        in_port = in_port ^ 8'h04;
        wr(2, 32'h4);
        seen = 1'b0;
        for (int n = 0; n < 24; n++) begin
            step();
            if (readdata[2]) seen = 1'b1;
        end
        check("collision_set_wins", 32'(seen), 32'h1);
        idle(0); step();
        check("collision_data", readdata, 32'h6);

        // Init window: switches already on through reset
        reset_n = 1'b0; m_reset(); in_port = 8'hFF; idle(0);
        repeat (3) step();
        reset_n = 1'b1;
        wr(1, 32'hFF); step(); idle(0);
        repeat (30) step();
        check("init_data", readdata, 32'hFF);
        address = 2'd2; step();
        check("init_edgecap", readdata, 32'h0);
        check("init_irq", 32'(irq), 32'h0);

        // Reset during the 2nd mismatching tick of bit0
        address = 2'd0; in_port = 8'hFE; guard = 0;
        while (!(m_streak[0] == 1 && (m_cyc % TD) == TD - 1) && guard < 40) begin
            step();
            guard++;
        end
        check("pend_reached", 32'(guard < 40), 32'h1);
        reset_n = 1'b0; m_reset();
        step();
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        step();
        reset_n = 1'b1;
        lat = -1;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            address = (k == 2) ? 2'd2 : 2'd0;
            step();
            if (k == 1) check("post_reset_data", readdata, 32'h0);
            if (k == 2) check("post_reset_edgecap", readdata, 32'h0);
            if (k > 2 && readdata == 32'hFE) lat = k;
        end
        check("restart_from_zero_step", 32'(lat), 32'd13);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)      in_port = W'($urandom);
            else if (r < 7) in_port[$urandom_range(0, W - 1)] = ~in_port[$urandom_range(0, W - 1)];
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 7) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0; m_reset();
                step();
                reset_n = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
